// File: rtl/jtag_dmi_intc.sv
// jtag_dmi_intc: passes one dsif {addr,data,op} request at a time onto the RISC-V DMI valid/ready port
// and returns {data,resp}. Define JTAG_DMI_INTC_TIMEOUT_EN to compile in the response timeout.
module jtag_dmi_intc #(
    parameter int DMI_ADDR_WIDTH = 7,
    parameter int DMI_DATA_WIDTH = 32,
    parameter int DMI_OP_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                                  jclk,
    input  logic                                                  dev_rst,
    input  logic                                                  jreq_vld,
    input  logic [DMI_ADDR_WIDTH+DMI_DATA_WIDTH+DMI_OP_WIDTH-1:0] jreq_data,
    output logic                                                  jreq_rdy,
    output logic                                                  jresp_vld,
    output logic [DMI_DATA_WIDTH+DMI_OP_WIDTH-1:0]                jresp_data,
    input  logic                                                  jresp_rdy,
    output logic                                                  dmi_req_valid,
    input  logic                                                  dmi_req_ready,
    output logic [DMI_ADDR_WIDTH-1:0]                             dmi_req_addr,
    output logic [DMI_DATA_WIDTH-1:0]                             dmi_req_data,
    output logic [DMI_OP_WIDTH-1:0]                               dmi_req_op,
    input  logic                                                  dmi_resp_valid,
    output logic                                                  dmi_resp_ready,
    input  logic [DMI_DATA_WIDTH-1:0]                             dmi_resp_data,
    input  logic [DMI_OP_WIDTH-1:0]                               dmi_resp_resp,
    output logic                                                  intc_busy
);

    localparam int OPW = DMI_OP_WIDTH;
    localparam int DW  = DMI_DATA_WIDTH;

    localparam logic [OPW-1:0] OP_READ   = OPW'(1);
    localparam logic [OPW-1:0] OP_WRITE  = OPW'(2);
    localparam logic [OPW-1:0] OP_RSVD   = OPW'(3);
    localparam logic [OPW-1:0] RESP_OK   = OPW'(0);
    localparam logic [OPW-1:0] RESP_FAIL = OPW'(2);

    if (DMI_OP_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("jtag_dmi_intc: DMI_OP_WIDTH must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        HOLD
    } state_t;

    state_t state_q;
    logic   jreqVld_q;

    logic [DMI_ADDR_WIDTH-1:0] reqAddr;
    logic [DW-1:0]             reqData;
    logic [OPW-1:0]            reqOp;
    logic                      capture;
    logic                      isAccess;
    logic                      tmoHit;

    assign reqAddr  = jreq_data[DMI_ADDR_WIDTH+DW+OPW-1:DW+OPW];
    assign reqData  = jreq_data[DW+OPW-1:OPW];
    assign reqOp    = jreq_data[OPW-1:0];
    assign capture  = jreq_vld & ~jreqVld_q;
    assign isAccess = (reqOp == OP_READ) || (reqOp == OP_WRITE);

`ifdef JTAG_DMI_INTC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmoCnt_q;

    // Held at zero outside REQ/RESP, so every entry to REQ starts a fresh count.
    always_ff @(posedge jclk) begin
        if (dev_rst || state_q == IDLE || state_q == HOLD) begin
            tmoCnt_q <= '0;
        end else begin
            tmoCnt_q <= tmoCnt_q + CNT_W'(1);
        end
    end

    assign tmoHit = ((state_q == REQ) || (state_q == RESP)) &&
                    (tmoCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmoHit = 1'b0;
`endif

    always_ff @(posedge jclk) begin
        if (dev_rst) begin
            state_q        <= IDLE;
            jreqVld_q      <= 1'b1;
            jreq_rdy       <= 1'b1;
            jresp_vld      <= 1'b0;
            jresp_data     <= '0;
            dmi_req_valid  <= 1'b0;
            dmi_req_addr   <= '0;
            dmi_req_data   <= '0;
            dmi_req_op     <= '0;
            dmi_resp_ready <= 1'b1;
            intc_busy      <= 1'b0;
        end else begin
            jreqVld_q <= jreq_vld;
            case (state_q)
                // Stray DMI responses are accepted and dropped here via dmi_resp_ready=1.
                IDLE: begin
                    if (capture) begin
                        dmi_req_addr   <= reqAddr;
                        dmi_req_data   <= reqData;
                        dmi_req_op     <= reqOp;
                        jreq_rdy       <= 1'b0;
                        intc_busy      <= 1'b1;
                        dmi_resp_ready <= 1'b0;
                        if (isAccess) begin
                            state_q       <= REQ;
                            dmi_req_valid <= 1'b1;
                        end else begin
                            state_q    <= HOLD;
                            jresp_vld  <= 1'b1;
                            jresp_data <= {{DW{1'b0}}, (reqOp == OP_RSVD) ? RESP_FAIL : RESP_OK};
                        end
                    end
                end
                REQ: begin
                    if (tmoHit) begin
                        state_q       <= HOLD;
                        dmi_req_valid <= 1'b0;
                        jresp_vld     <= 1'b1;
                        jresp_data    <= {{DW{1'b0}}, RESP_FAIL};
                    end else if (dmi_req_ready) begin
                        state_q        <= RESP;
                        dmi_req_valid  <= 1'b0;
                        dmi_resp_ready <= 1'b1;
                    end
                end
                // A response arriving in the timeout cycle still wins.
                RESP: begin
                    if (dmi_resp_valid) begin
                        state_q        <= HOLD;
                        dmi_resp_ready <= 1'b0;
                        jresp_vld      <= 1'b1;
                        jresp_data     <= {dmi_resp_data, dmi_resp_resp};
                    end else if (tmoHit) begin
                        state_q        <= HOLD;
                        dmi_resp_ready <= 1'b0;
                        jresp_vld      <= 1'b1;
                        jresp_data     <= {{DW{1'b0}}, RESP_FAIL};
                    end
                end
                HOLD: begin
                    if (jresp_rdy) begin
                        state_q        <= IDLE;
                        jresp_vld      <= 1'b0;
                        jreq_rdy       <= 1'b1;
                        intc_busy      <= 1'b0;
                        dmi_resp_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    jreq_rdy       <= 1'b1;
                    jresp_vld      <= 1'b0;
                    dmi_req_valid  <= 1'b0;
                    dmi_resp_ready <= 1'b1;
                    intc_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_dmi_intc.sv
// tb_jtag_dmi_intc: directed vectors plus hand sequences for jtag_dmi_intc; inputs change 2ns after
// the rising edge and outputs are sampled on the falling edge.
module tb_jtag_dmi_intc;

    localparam int A = 7;
    localparam int D = 32;
    localparam int O = 2;

    logic             jclk = 1'b0;
    logic             dev_rst;
    logic             jreq_vld;
    logic [A+D+O-1:0] jreq_data;
    logic             jreq_rdy;
    logic             jresp_vld;
    logic [D+O-1:0]   jresp_data;
    logic             jresp_rdy;
    logic             dmi_req_valid;
    logic             dmi_req_ready;
    logic [A-1:0]     dmi_req_addr;
    logic [D-1:0]     dmi_req_data;
    logic [O-1:0]     dmi_req_op;
    logic             dmi_resp_valid;
    logic             dmi_resp_ready;
    logic [D-1:0]     dmi_resp_data;
    logic [O-1:0]     dmi_resp_resp;
    logic             intc_busy;

    jtag_dmi_intc #(
        .DMI_ADDR_WIDTH(A),
        .DMI_DATA_WIDTH(D),
        .DMI_OP_WIDTH  (O),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .jclk          (jclk),
        .dev_rst       (dev_rst),
        .jreq_vld      (jreq_vld),
        .jreq_data     (jreq_data),
        .jreq_rdy      (jreq_rdy),
        .jresp_vld     (jresp_vld),
        .jresp_data    (jresp_data),
        .jresp_rdy     (jresp_rdy),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_data  (dmi_req_data),
        .dmi_req_op    (dmi_req_op),
        .dmi_resp_valid(dmi_resp_valid),
        .dmi_resp_ready(dmi_resp_ready),
        .dmi_resp_data (dmi_resp_data),
        .dmi_resp_resp (dmi_resp_resp),
        .intc_busy     (intc_busy)
    );

    always #5 jclk = ~jclk;

    typedef struct {
        logic [A-1:0]   addr;
        logic [D-1:0]   data;
        logic [O-1:0]   op;
        logic [D-1:0]   rdata;
        logic [O-1:0]   rresp;
        logic [D+O-1:0] expResp;
        int             expXfers;
        int             expLat;
    } vec_t;

    vec_t vecs[6];

    int vecCount = 0;
    int errCount = 0;

    int xferCount, stallCount, fieldBad, respHs, rdyBusyBad;
    logic [A-1:0] monAddr;
    logic [D-1:0] monData;
    logic [O-1:0] monOp;

    logic [D+O-1:0] r;
    int             lat;
    bit             got;

    // Observes DMI request handshakes and field stability once per cycle.
    always @(negedge jclk) begin
        if (dmi_req_valid) begin
            if (dmi_req_ready) xferCount++;
            else stallCount++;
            if (dmi_req_addr !== monAddr || dmi_req_data !== monData || dmi_req_op !== monOp)
                fieldBad++;
        end
        if (jresp_vld && jresp_rdy) respHs++;
        if (jreq_rdy && intc_busy) rdyBusyBad++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic driveEdge();
        @(posedge jclk);
        #2;
    endtask

    task automatic clearMon(input logic [A-1:0] a, input logic [D-1:0] d, input logic [O-1:0] o);
        xferCount  = 0;
        stallCount = 0;
        fieldBad   = 0;
        respHs     = 0;
        rdyBusyBad = 0;
        monAddr    = a;
        monData    = d;
        monOp      = o;
    endtask

    // Raises jreq_vld with one request; latency counts the cycle of the rise as cycle 1.
    task automatic applyStimulus(input logic [A-1:0] a, input logic [D-1:0] d, input logic [O-1:0] o,
                                 output logic [D+O-1:0] resp, output int latency, output bit ok);
        clearMon(a, d, o);
        jreq_data = {a, d, o};
        jreq_vld  = 1'b1;
        ok        = 1'b0;
        latency   = 0;
        resp      = '0;
        for (int i = 1; i <= 200 && !ok; i++) begin
            @(negedge jclk);
            if (jresp_vld) begin
                ok      = 1'b1;
                latency = i;
                resp    = jresp_data;
            end
        end
        if (!ok) checkOutput("response wait", 64'(ok), 64'd1);
        driveEdge();
        jreq_vld = 1'b0;
        driveEdge();
    endtask

    initial begin
        vecs[0] = '{7'h11, 32'h0,        2'd1, 32'hDEADBEEF, 2'd0, {32'hDEADBEEF, 2'b00}, 1, 4};
        vecs[1] = '{7'h10, 32'h80000001, 2'd2, 32'h12345678, 2'd0, {32'h12345678, 2'b00}, 1, 4};
        vecs[2] = '{7'h7F, 32'h0,        2'd1, 32'hA5A5A5A5, 2'd2, {32'hA5A5A5A5, 2'b10}, 1, 4};
        vecs[3] = '{7'h00, 32'hFFFFFFFF, 2'd3, 32'h11111111, 2'd0, {32'h0, 2'b10},        0, 2};
        vecs[4] = '{7'h22, 32'h00000055, 2'd0, 32'h00000001, 2'd0, {32'h0, 2'b00},        0, 2};
        vecs[5] = '{7'h01, 32'h0,        2'd1, 32'hCAFEF00D, 2'd3, {32'hCAFEF00D, 2'b11}, 1, 4};

        dev_rst        = 1'b1;
        jreq_vld       = 1'b1;
        jreq_data      = '0;
        jresp_rdy      = 1'b1;
        dmi_req_ready  = 1'b1;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = '0;
        dmi_resp_resp  = '0;
        clearMon('0, '0, '0);

        repeat (3) driveEdge();
        @(negedge jclk);
        checkOutput("reset jreq_rdy", 64'(jreq_rdy), 64'd1);
        checkOutput("reset jresp_vld", 64'(jresp_vld), 64'd0);
        checkOutput("reset jresp_data", 64'(jresp_data), 64'd0);
        checkOutput("reset dmi_req_valid", 64'(dmi_req_valid), 64'd0);
        checkOutput("reset dmi_req fields", 64'({dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);
        checkOutput("reset dmi_resp_ready", 64'(dmi_resp_ready), 64'd1);
        checkOutput("reset intc_busy", 64'(intc_busy), 64'd0);

        // jreq_vld was high through reset, so releasing reset must not start a transaction.
        driveEdge();
        dev_rst = 1'b0;
        repeat (3) driveEdge();
        @(negedge jclk);
        checkOutput("held-through-reset no capture", 64'(intc_busy), 64'd0);
        driveEdge();
        jreq_vld = 1'b0;
        driveEdge();

        for (int v = 0; v < 6; v++) begin
            dmi_resp_valid = 1'b1;
            dmi_resp_data  = vecs[v].rdata;
            dmi_resp_resp  = vecs[v].rresp;
            applyStimulus(vecs[v].addr, vecs[v].data, vecs[v].op, r, lat, got);
            checkOutput($sformatf("vec%0d jresp_data", v), 64'(r), 64'(vecs[v].expResp));
            checkOutput($sformatf("vec%0d latency", v), 64'(lat), 64'(vecs[v].expLat));
            checkOutput($sformatf("vec%0d dmi transfers", v), 64'(xferCount), 64'(vecs[v].expXfers));
            checkOutput($sformatf("vec%0d dmi fields", v), 64'(fieldBad), 64'd0);
            checkOutput($sformatf("vec%0d jresp handshakes", v), 64'(respHs), 64'd1);
        end

        // Write with five stalled request cycles and a slow response consumer.
        dmi_req_ready  = 1'b0;
        jresp_rdy      = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'hFEEDFACE;
        dmi_resp_resp  = 2'd0;
        clearMon(7'h10, 32'h80000001, 2'd2);
        jreq_data = {7'h10, 32'h80000001, 2'd2};
        jreq_vld  = 1'b1;
        repeat (6) driveEdge();
        dmi_req_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge jclk);
            if (jresp_vld) got = 1'b1;
        end
        checkOutput("bp jresp_vld seen", 64'(got), 64'd1);
        repeat (4) driveEdge();
        @(negedge jclk);
        checkOutput("bp jresp_vld held", 64'(jresp_vld), 64'd1);
        checkOutput("bp jresp_data", 64'(jresp_data), 64'({32'hFEEDFACE, 2'b00}));
        checkOutput("bp jreq_rdy while busy", 64'(jreq_rdy), 64'd0);
        driveEdge();
        jresp_rdy = 1'b1;
        jreq_vld  = 1'b0;
        driveEdge();
        @(negedge jclk);
        checkOutput("bp jresp_vld released", 64'(jresp_vld), 64'd0);
        checkOutput("bp jreq_rdy restored", 64'(jreq_rdy), 64'd1);
        checkOutput("bp stall cycles", 64'(stallCount), 64'd5);
        checkOutput("bp dmi transfers", 64'(xferCount), 64'd1);
        checkOutput("bp field stability", 64'(fieldBad), 64'd0);
        driveEdge();

        // Request level held for 20 cycles must issue exactly once.
        dmi_resp_data = 32'h00C0FFEE;
        clearMon(7'h05, 32'h0, 2'd1);
        jreq_data = {7'h05, 32'h0, 2'd1};
        jreq_vld  = 1'b1;
        driveEdge();
        @(negedge jclk);
        checkOutput("held jreq_rdy low", 64'(jreq_rdy), 64'd0);
        repeat (19) driveEdge();
        jreq_vld = 1'b0;
        repeat (3) driveEdge();
        @(negedge jclk);
        checkOutput("held dmi transfers", 64'(xferCount), 64'd1);
        checkOutput("held jresp handshakes", 64'(respHs), 64'd1);
        checkOutput("held jreq_rdy vs busy", 64'(rdyBusyBad), 64'd0);
        checkOutput("held jreq_rdy final", 64'(jreq_rdy), 64'd1);
        driveEdge();

        // Reset while waiting in RESP, then a stray response that must be dropped.
        dmi_resp_valid = 1'b0;
        clearMon(7'h33, 32'h0, 2'd1);
        jreq_data = {7'h33, 32'h0, 2'd1};
        jreq_vld  = 1'b1;
        repeat (2) driveEdge();
        @(negedge jclk);
        checkOutput("rst-in-resp busy", 64'(intc_busy), 64'd1);
        checkOutput("rst-in-resp dmi_resp_ready", 64'(dmi_resp_ready), 64'd1);
        #1 dev_rst = 1'b1;
        driveEdge();
        dev_rst        = 1'b0;
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h5A5A5A5A;
        @(negedge jclk);
        checkOutput("rst-in-resp outputs",
                    64'({jreq_rdy, jresp_vld, dmi_req_valid, dmi_resp_ready, intc_busy}), 64'b10010);
        checkOutput("rst-in-resp jresp_data", 64'(jresp_data), 64'd0);
        checkOutput("rst-in-resp dmi_req fields", 64'({dmi_req_addr, dmi_req_op}), 64'd0);
        repeat (3) driveEdge();
        dmi_resp_valid = 1'b0;
        @(negedge jclk);
        checkOutput("stray resp dropped", 64'({jresp_vld, intc_busy}), 64'd0);
        checkOutput("stray resp no handshake", 64'(respHs), 64'd0);
        driveEdge();
        jreq_vld = 1'b0;
        driveEdge();
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h76543210;
        dmi_resp_resp  = 2'd0;
        applyStimulus(7'h44, 32'h0, 2'd1, r, lat, got);
        checkOutput("post-reset read data", 64'(r), 64'({32'h76543210, 2'b00}));
        checkOutput("post-reset read latency", 64'(lat), 64'd4);

        // No DMI response at all.
        dmi_resp_valid = 1'b0;
`ifdef JTAG_DMI_INTC_TIMEOUT_EN
        applyStimulus(7'h12, 32'h0, 2'd1, r, lat, got);
        checkOutput("timeout jresp_data", 64'(r), 64'({32'h0, 2'b10}));
        checkOutput("timeout latency", 64'(lat), 64'd10);
        checkOutput("timeout dmi transfers", 64'(xferCount), 64'd1);
        dmi_resp_valid = 1'b1;
        repeat (2) driveEdge();
        dmi_resp_valid = 1'b0;
        @(negedge jclk);
        checkOutput("late resp dropped", 64'({jresp_vld, intc_busy}), 64'd0);
        driveEdge();
`else
        clearMon(7'h12, 32'h0, 2'd1);
        jreq_data = {7'h12, 32'h0, 2'd1};
        jreq_vld  = 1'b1;
        repeat (100) driveEdge();
        @(negedge jclk);
        checkOutput("no-timeout still waiting", 64'({jresp_vld, intc_busy}), 64'b01);
        driveEdge();
        dmi_resp_valid = 1'b1;
        dmi_resp_data  = 32'h0BADF00D;
        got = 1'b0;
        r   = '0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge jclk);
            if (jresp_vld) begin
                got = 1'b1;
                r   = jresp_data;
            end
        end
        checkOutput("no-timeout eventual resp", 64'(r), 64'({32'h0BADF00D, 2'b00}));
        driveEdge();
        jreq_vld       = 1'b0;
        dmi_resp_valid = 1'b0;
        driveEdge();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000ns");
        $fatal(1);
    end

endmodule
